// File: rtl/instr_fetch_unit_pkg.sv
// Shared processor definitions used by the fetch unit, the instruction ROM and the control unit.
package instr_fetch_unit_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    HOLD  = 2'd2,
    FAULT = 2'd3
  } fetch_state_e;

  localparam int unsigned DEF_ADDR_W   = 17;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] DEF_NOP_INST = 32'h0000_0013;

endpackage

// File: rtl/instr_fetch_unit.sv
// Instruction fetch initiator: owns the PC, waits on the ROM, and holds the fetched word
// in the instruction register under a valid/ready handshake with the control unit.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int unsigned       ADDR_W      = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC    = DEF_RESET_PC[ADDR_W-1:0],
  parameter int unsigned       ROM_LATENCY = 0,
  parameter logic [31:0]       NOP_INST    = DEF_NOP_INST
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              fetch_req,
  output logic              inst_valid,
  input  logic              inst_ready,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [31:0]       rom_inst,
  output logic [31:0]       ir,
  output logic [ADDR_W-1:0] ir_pc,
  output logic [ADDR_W-1:0] pc,
  output logic              fault
);

  localparam int unsigned       CNT_W    = (ROM_LATENCY > 0) ? $clog2(ROM_LATENCY + 1) : 1;
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(ROM_LATENCY);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(32'd1);
  localparam logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(32'd4);

  fetch_state_e      state_r, state_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  logic [ADDR_W-1:0] pc_r, pc_s;
  logic [ADDR_W-1:0] ir_pc_r, ir_pc_s;
  logic [31:0]       ir_r, ir_s;
  logic              valid_r, valid_s;
  logic              fault_r, fault_s;

  // pc only moves in IDLE, FAULT or on a HOLD handshake, so the ROM address is stable in REQ.
  assign rom_addr   = pc_r;
  assign pc         = pc_r;
  assign ir         = ir_r;
  assign ir_pc      = ir_pc_r;
  assign inst_valid = valid_r;
  assign fault      = fault_r;

  // Next-state and next-register logic for the fetch sequencer.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    pc_s    = pc_r;
    ir_s    = ir_r;
    ir_pc_s = ir_pc_r;
    valid_s = valid_r;
    fault_s = fault_r;
    case (state_r)
      IDLE: begin
        if (redirect_valid) begin
          pc_s = redirect_target;
        end else if (fetch_req && (pc_r[1:0] != 2'b00)) begin
          state_s = FAULT;
          fault_s = 1'b1;
        end else if (fetch_req) begin
          state_s = REQ;
          cnt_s   = CNT_LOAD;
        end else begin
          state_s = IDLE;
        end
      end
      REQ: begin
        if (cnt_r != '0) begin
          cnt_s = cnt_r - CNT_ONE;
        end else begin
          ir_s    = rom_inst;
          ir_pc_s = pc_r;
          valid_s = 1'b1;
          state_s = HOLD;
        end
      end
      HOLD: begin
        if (inst_ready) begin
          valid_s = 1'b0;
          state_s = IDLE;
          if (redirect_valid) begin
            pc_s = redirect_target;
          end else begin
            pc_s = pc_r + PC_STEP;
          end
        end else begin
          valid_s = 1'b1;
        end
      end
      FAULT: begin
        valid_s = 1'b0;
        if (redirect_valid) begin
          // A misaligned target still loads pc but keeps the unit parked here.
          pc_s = redirect_target;
          if (redirect_target[1:0] == 2'b00) begin
            fault_s = 1'b0;
            state_s = IDLE;
          end else begin
            fault_s = 1'b1;
          end
        end else begin
          fault_s = 1'b1;
        end
      end
      default: begin
        state_s = IDLE;
        valid_s = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset abandons any in-flight fetch.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      pc_r    <= RESET_PC;
      ir_r    <= NOP_INST;
      ir_pc_r <= '0;
      valid_r <= 1'b0;
      fault_r <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      pc_r    <= pc_s;
      ir_r    <= ir_s;
      ir_pc_r <= ir_pc_s;
      valid_r <= valid_s;
      fault_r <= fault_s;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: one instance with a combinational ROM, one with two wait cycles.
module tb_instr_fetch_unit;

  logic        clock;
  logic        reset_n;

  logic        a_fetch_req, a_inst_ready, a_redirect_valid;
  logic [16:0] a_redirect_target, a_rom_addr, a_ir_pc, a_pc;
  logic [31:0] a_rom_inst, a_ir;
  logic        a_inst_valid, a_fault;

  logic        b_fetch_req, b_inst_ready, b_redirect_valid;
  logic [16:0] b_redirect_target, b_rom_addr, b_ir_pc, b_pc;
  logic [31:0] b_rom_inst, b_ir;
  logic        b_inst_valid, b_fault;

  int total;
  int bad;

  instr_fetch_unit #(.ADDR_W(17), .ROM_LATENCY(0)) dut_a (
    .clock(clock), .reset_n(reset_n), .fetch_req(a_fetch_req), .inst_valid(a_inst_valid),
    .inst_ready(a_inst_ready), .redirect_valid(a_redirect_valid), .redirect_target(a_redirect_target),
    .rom_addr(a_rom_addr), .rom_inst(a_rom_inst), .ir(a_ir), .ir_pc(a_ir_pc), .pc(a_pc), .fault(a_fault)
  );

  instr_fetch_unit #(.ADDR_W(17), .ROM_LATENCY(2)) dut_b (
    .clock(clock), .reset_n(reset_n), .fetch_req(b_fetch_req), .inst_valid(b_inst_valid),
    .inst_ready(b_inst_ready), .redirect_valid(b_redirect_valid), .redirect_target(b_redirect_target),
    .rom_addr(b_rom_addr), .rom_inst(b_rom_inst), .ir(b_ir), .ir_pc(b_ir_pc), .pc(b_pc), .fault(b_fault)
  );

  // ROM contents: words 0 and 1 are real instructions, every other word encodes its own index.
  function automatic logic [31:0] rom_word(input logic [16:0] addr);
    logic [14:0] idx;
    idx = addr[16:2];
    case (idx)
      15'd0:   return 32'h0020_0093;
      15'd1:   return 32'h0030_0113;
      default: return 32'hA500_0000 | {17'd0, idx};
    endcase
  endfunction

  assign a_rom_inst = rom_word(a_rom_addr);
  assign b_rom_inst = rom_word(b_rom_addr);

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset_n = 1'b0;
    a_fetch_req = 1'b0; a_inst_ready = 1'b0; a_redirect_valid = 1'b0; a_redirect_target = 17'h0;
    b_fetch_req = 1'b0; b_inst_ready = 1'b0; b_redirect_valid = 1'b0; b_redirect_target = 17'h0;
    #12;
    chk("rst_pc", {15'd0, a_pc}, 32'h0);
    chk("rst_ir", a_ir, 32'h0000_0013);
    chk("rst_ir_pc", {15'd0, a_ir_pc}, 32'h0);
    chk("rst_valid", {31'd0, a_inst_valid}, 32'h0);
    chk("rst_fault", {31'd0, a_fault}, 32'h0);

    // Back-to-back fetches with ROM_LATENCY=0, request and ready held high.
    reset_n = 1'b1;
    a_fetch_req = 1'b1; a_inst_ready = 1'b1;
    tick();                                                    // edge 1
    chk("b2b_e1_valid", {31'd0, a_inst_valid}, 32'h0);
    tick();                                                    // edge 2
    chk("b2b_e2_valid", {31'd0, a_inst_valid}, 32'h1);
    chk("b2b_e2_ir", a_ir, 32'h0020_0093);
    chk("b2b_e2_ir_pc", {15'd0, a_ir_pc}, 32'h0);
    tick();                                                    // edge 3
    chk("b2b_e3_valid", {31'd0, a_inst_valid}, 32'h0);
    chk("b2b_e3_pc", {15'd0, a_pc}, 32'h4);
    tick();                                                    // edge 4
    chk("b2b_e4_valid", {31'd0, a_inst_valid}, 32'h0);
    tick();                                                    // edge 5
    chk("b2b_e5_valid", {31'd0, a_inst_valid}, 32'h1);
    chk("b2b_e5_ir", a_ir, 32'h0030_0113);
    chk("b2b_e5_ir_pc", {15'd0, a_ir_pc}, 32'h4);
    a_fetch_req = 1'b0;
    tick();
    chk("b2b_pc8", {15'd0, a_pc}, 32'h8);

    // HOLD at pc=8 with a redirect on the handshake.
    a_fetch_req = 1'b1; a_inst_ready = 1'b0;
    tick(); tick();
    chk("rd_hold_ir", a_ir, 32'hA500_0002);
    chk("rd_hold_ir_pc", {15'd0, a_ir_pc}, 32'h8);
    a_fetch_req = 1'b0; a_inst_ready = 1'b1; a_redirect_valid = 1'b1; a_redirect_target = 17'h18;
    tick();
    chk("rd_pc", {15'd0, a_pc}, 32'h18);
    chk("rd_rom_addr", {15'd0, a_rom_addr}, 32'h18);
    chk("rd_valid_low", {31'd0, a_inst_valid}, 32'h0);
    a_redirect_valid = 1'b0; a_inst_ready = 1'b0; a_fetch_req = 1'b1;
    tick(); tick();
    chk("rd_fetch_ir", a_ir, 32'hA500_0006);
    chk("rd_fetch_ir_pc", {15'd0, a_ir_pc}, 32'h18);

    // Redirect without ready is ignored; plain handshake steps pc by 4.
    a_fetch_req = 1'b0; a_redirect_valid = 1'b1; a_redirect_target = 17'h40;
    tick();
    chk("noready_pc", {15'd0, a_pc}, 32'h18);
    chk("noready_valid", {31'd0, a_inst_valid}, 32'h1);
    a_redirect_valid = 1'b0; a_inst_ready = 1'b1;
    tick();
    chk("step_pc", {15'd0, a_pc}, 32'h1C);

    // Misaligned fetch, misaligned recovery attempt, then aligned recovery.
    a_inst_ready = 1'b0; a_redirect_valid = 1'b1; a_redirect_target = 17'h6;
    tick();
    chk("mis_pc", {15'd0, a_pc}, 32'h6);
    chk("mis_nofault_yet", {31'd0, a_fault}, 32'h0);
    a_redirect_valid = 1'b0; a_fetch_req = 1'b1;
    tick();
    chk("flt_fault", {31'd0, a_fault}, 32'h1);
    chk("flt_valid", {31'd0, a_inst_valid}, 32'h0);
    tick();
    chk("flt_sticky", {31'd0, a_fault}, 32'h1);
    chk("flt_ir_held", a_ir, 32'hA500_0006);
    a_fetch_req = 1'b0; a_redirect_valid = 1'b1; a_redirect_target = 17'h2;
    tick();
    chk("flt_mis_pc", {15'd0, a_pc}, 32'h2);
    chk("flt_mis_fault", {31'd0, a_fault}, 32'h1);
    a_redirect_target = 17'h4;
    tick();
    chk("flt_clr_fault", {31'd0, a_fault}, 32'h0);
    chk("flt_clr_pc", {15'd0, a_pc}, 32'h4);
    a_redirect_valid = 1'b0; a_fetch_req = 1'b1;
    tick(); tick();
    chk("flt_next_ir", a_ir, 32'h0030_0113);
    chk("flt_next_valid", {31'd0, a_inst_valid}, 32'h1);

    // PC wrap at the top of the address space.
    a_fetch_req = 1'b0; a_inst_ready = 1'b1; a_redirect_valid = 1'b1; a_redirect_target = 17'h1FFFC;
    tick();
    chk("wrap_pc_load", {15'd0, a_pc}, 32'h1FFFC);
    a_redirect_valid = 1'b0; a_inst_ready = 1'b0; a_fetch_req = 1'b1;
    tick(); tick();
    chk("wrap_ir_pc", {15'd0, a_ir_pc}, 32'h1FFFC);
    chk("wrap_ir", a_ir, 32'hA500_7FFF);
    a_fetch_req = 1'b0; a_inst_ready = 1'b1;
    tick();
    chk("wrap_pc", {15'd0, a_pc}, 32'h0);
    a_inst_ready = 1'b0; a_fetch_req = 1'b1;
    tick(); tick();
    chk("wrap_next_ir", a_ir, 32'h0020_0093);

    // Park instance A in FAULT so the later reset must clear it.
    a_fetch_req = 1'b0; a_inst_ready = 1'b1; a_redirect_valid = 1'b1; a_redirect_target = 17'h2;
    tick();
    a_redirect_valid = 1'b0; a_inst_ready = 1'b0; a_fetch_req = 1'b1;
    tick();
    chk("park_fault", {31'd0, a_fault}, 32'h1);
    a_fetch_req = 1'b0;

    // ROM_LATENCY=2 single fetch: valid after edge 4, rom_addr steady through REQ.
    b_fetch_req = 1'b1;
    tick();                                                    // edge 1
    b_fetch_req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("lat2_wait_valid", {31'd0, b_inst_valid}, 32'h0);
      chk("lat2_rom_addr", {15'd0, b_rom_addr}, 32'h0);
      tick();                                                  // edges 2, 3
    end
    chk("lat2_e3_valid", {31'd0, b_inst_valid}, 32'h0);
    tick();                                                    // edge 4
    chk("lat2_e4_valid", {31'd0, b_inst_valid}, 32'h1);
    chk("lat2_e4_ir", b_ir, 32'h0020_0093);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("lat2_hold_valid", {31'd0, b_inst_valid}, 32'h1);
      chk("lat2_hold_ir", b_ir, 32'h0020_0093);
    end
    b_inst_ready = 1'b1;
    tick();
    chk("lat2_hs_valid", {31'd0, b_inst_valid}, 32'h0);
    chk("lat2_hs_pc", {15'd0, b_pc}, 32'h4);

    // Reset while instance B is in REQ takes effect immediately.
    b_inst_ready = 1'b0; b_fetch_req = 1'b1;
    tick();
    b_fetch_req = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_pc", {15'd0, b_pc}, 32'h0);
    chk("mid_rst_ir", b_ir, 32'h0000_0013);
    chk("mid_rst_valid", {31'd0, b_inst_valid}, 32'h0);
    chk("mid_rst_fault_a", {31'd0, a_fault}, 32'h0);
    chk("mid_rst_ir_a", a_ir, 32'h0000_0013);
    reset_n = 1'b1;
    tick(); tick(); tick();
    chk("post_rst_valid", {31'd0, b_inst_valid}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
